uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares the single UART transmitter behind the RS-232 controller between several byte sources, such as the switch-send path and a receive-echo path. Each requester hands over one byte through a valid/ready handshake into a private one-entry holding register. The arbiter then sequences the transmitter one frame at a time using a start pulse and a busy handshake. It sits between the requesters and the transmitter's tx_start/tx_data/tx_busy pins.

## Interface
- NREQ, 2: number of requesters, 2..8.
- DATA_W, 8: byte width.
- GW, $clog2(NREQ) (minimum 1): grant index width; derived, not overridden.

- clk  in  1  system clock (50 MHz); every register is clocked on its rising edge.
- rst_n  in  1  reset.
  - One clock; reset is synchronous and active-low.
- req_valid  in  NREQ  per-requester byte valid.
- req_data  in  NREQ*DATA_W  requester i's byte is at bits [i*DATA_W +: DATA_W].
- req_ready  out  NREQ  holding register i is empty; equals ~pending[i].
- tx_start  out  1  one-cycle launch pulse to the transmitter.
- tx_data  out  DATA_W  byte to transmit; stable from the tx_start cycle until the frame completes.
- tx_busy  in  1  transmitter frame in progress.
- grant_id  out  GW  index of the requester currently being served; holds its last value when idle.
- busy  out  1  high whenever state != IDLE.

## Operation
- Holding registers:
  - When req_valid[i] & req_ready[i] is high at a clock edge, load req_data slice i into hold[i] and set pending[i].
  - While pending[i] is set, req_valid[i] is ignored. No overwrite.
- State machine (registered):
  - IDLE: if any pending bit is set, choose the winner by round-robin (below), register grant_id, load tx_data from hold[winner], go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: tx_start = 1 for this one cycle only. Go to WAIT_BUSY.
  - WAIT_BUSY: stay until tx_busy = 1, then go to WAIT_DONE. If tx_busy is already 1 in the first WAIT_BUSY cycle, move on immediately.
  - WAIT_DONE: stay until tx_busy = 0. On that edge, clear pending[grant_id], set last = grant_id, go to IDLE.
- Round-robin:
  - Search order is last+1, last+2, …, wrapping modulo NREQ, ending at last.
  - The first pending index in that order wins.
  - last resets to NREQ-1, so requester 0 has first priority out of reset.
- Simultaneous events:
  - A new request from requester j arriving while j is being served is impossible, because req_ready[j] = 0.
  - Requests from other requesters are accepted at any time, including during WAIT_DONE.
  - On the edge that clears pending[g], req_ready[g] rises in the following cycle. There is no same-cycle reload bypass.
  - A requester accepted on the same edge the FSM leaves WAIT_DONE is eligible in the very next IDLE cycle.
- Fairness: with all NREQ requesters continuously pending, each is granted exactly once per NREQ frames.
- tx_busy stuck low after tx_start is not timed out: the FSM waits in WAIT_BUSY indefinitely. The transmitter contract requires busy to assert within a few cycles of tx_start.

## Timing
- Reset (rst_n = 0 at a rising edge) forces:
  - state = IDLE, pending = 0, last = NREQ-1
  - tx_start = 0, tx_data = 0, grant_id = 0, busy = 0
  - req_ready = all ones from the first cycle after reset
- Reset mid-frame:
  - Pending bytes are discarded and the current frame is abandoned.
  - The transmitter shares rst_n and aborts as well.
- Latency:
  - Handshake sampled at edge E0; pending visible in cycle E0+1.
  - The IDLE decision registers at edge E1, so tx_start is high in the cycle after E1: 2 edges after acceptance.
- Back-to-back frames: tx_busy falls at edge F. IDLE is the cycle after F, and the next tx_start is 2 cycles after F. Minimum gap is 2 idle cycles between frames.
- tx_start is registered and glitch-free. It is never high for 2 consecutive cycles.
- tx_data and grant_id change only on the IDLE→LAUNCH edge.

## Test plan
- Reset:
  - Hold rst_n = 0 for 3 cycles with req_valid = 2'b11.
  - Expect tx_start = 0, busy = 0, pending cleared, req_ready = 2'b11 after release.
- Single request:
  - Requester 0 sends 0xA5.
  - Expect tx_start exactly 2 cycles after the handshake, tx_data = 0xA5, grant_id = 0.
  - Model tx_busy high for 10 cycles; req_ready[0] returns 1 the cycle after busy falls.
- Simultaneous:
  - Requester 0 sends 0x11 and requester 1 sends 0x22 in the same cycle, out of reset.
  - Expect frames in order 0x11 then 0x22, grant_id 0 then 1.
  - Expect a 2-cycle gap between busy falling and the second tx_start.
- Fairness (NREQ = 3):
  - Keep all requesters reloading immediately when ready.
  - Over 9 frames expect the grant sequence 0,1,2,0,1,2,0,1,2.
- Blocked overwrite:
  - While 0x3C from requester 1 is in WAIT_DONE, drive req_valid[1] with 0xFF.
  - Expect req_ready[1] = 0, hold unchanged, and the transmitted byte 0x3C.
  - 0xFF is accepted only after the frame completes.
- Mid-frame reset:
  - Assert rst_n = 0 during WAIT_DONE with requester 1 pending.
  - Expect immediate return to IDLE, no further tx_start, and pending = 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ byte sources.
// Each source hands over one byte into a private holding register; the FSM
// then launches one frame at a time through the tx_start/tx_busy handshake.
module uart_tx_arbiter #(
  parameter int NREQ   = 2,
  parameter int DATA_W = 8,
  localparam int GW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*DATA_W-1:0]   req_data_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic                     tx_start_o,
  output logic [DATA_W-1:0]        tx_data_o,
  input  logic                     tx_busy_i,
  output logic [GW-1:0]            grant_id_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  state_e              state_q;
  logic [NREQ-1:0]     pending_q;
  logic [NREQ-1:0]     pending_d;
  logic [NREQ-1:0]     accept;
  logic [NREQ-1:0]     clearMask;
  logic [DATA_W-1:0]   hold_q [NREQ];
  logic [GW-1:0]       last_q;
  logic [GW-1:0]       grant_q;
  logic [GW-1:0]       winner;
  logic [GW-1:0]       cand;
  logic                winnerValid;
  logic [DATA_W-1:0]   txData_q;
  logic                txStart_q;
  logic                busy_q;
  logic                frameDone;
  int                  idx;

  assign accept      = req_valid_i & ~pending_q;
  assign frameDone   = (state_q == WAIT_DONE) && !tx_busy_i;
  assign req_ready_o = ~pending_q;
  assign tx_start_o  = txStart_q;
  assign tx_data_o   = txData_q;
  assign grant_id_o  = grant_q;
  assign busy_o      = busy_q;

  // Next pending flags: set on an accepted handshake, cleared when the served frame completes
  always_comb begin
    clearMask = '0;
    if (frameDone) begin
      clearMask[grant_q] = 1'b1;
    end
    pending_d = (pending_q | accept) & ~clearMask;
  end

  // Pending flags; a set flag blocks its requester until its frame has been sent
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Holding registers capture a byte only when the slot is empty, so no overwrite is possible
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NREQ; i++) begin
      if (accept[i]) begin
        hold_q[i] <= req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Round-robin search from last+1 upward; scanning backwards lets the earliest hit win
  always_comb begin
    winnerValid = 1'b0;
    winner      = '0;
    idx         = 0;
    cand        = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx  = (int'(last_q) + k) % NREQ;
      cand = GW'(idx);
      if (pending_q[cand]) begin
        winnerValid = 1'b1;
        winner      = cand;
      end
    end
  end

  // Frame sequencer with registered tx_start, tx_data, grant_id and busy
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      last_q    <= GW'(NREQ - 1);
      grant_q   <= '0;
      txData_q  <= '0;
      txStart_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      txStart_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (winnerValid) begin
            grant_q   <= winner;
            txData_q  <= hold_q[winner];
            txStart_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= LAUNCH;
          end
        end
        LAUNCH: begin
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy_i) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy_i) begin
            last_q  <= grant_q;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter with three requesters. A behavioural model
// predicts each frame launch (cycle, winner, byte) into a queue, and an
// independent monitor pops and compares whenever tx_start is seen.
module tb_uart_tx_arbiter;

  localparam int NREQ   = 3;
  localparam int DATA_W = 8;
  localparam int GW     = 2;

  logic                   clk;
  logic                   rst_n;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*DATA_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   tx_start;
  logic [DATA_W-1:0]      tx_data;
  logic                   tx_busy;
  logic [GW-1:0]          grant_id;
  logic                   busy;

  typedef struct {
    int                cyc;
    int                grant;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   grantLog[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  bit                     modelKnown = 1'b0;
  logic [NREQ-1:0]        mPending;
  logic [NREQ*DATA_W-1:0] mHoldV;
  int                     mLast;
  int                     mGrant;
  bit                     mInFrame;
  bit                     mBusySeen;
  logic [DATA_W-1:0]      mCurByte;

  bit txFixed;
  bit txActive;
  int txDelay;
  int txHold;
  bit logGrants;

  uart_tx_arbiter #(
    .NREQ   (NREQ),
    .DATA_W (DATA_W)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .tx_start_o  (tx_start),
    .tx_data_o   (tx_data),
    .tx_busy_i   (tx_busy),
    .grant_id_o  (grant_id),
    .busy_o      (busy)
  );

  // Free-running 100 MHz-style bench clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle index: during cycle n (after the n-th rising edge) cyc equals n
  always @(posedge clk) cyc <= cyc + 1;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit bitAt(input logic [31:0] v, input int i);
    logic [4:0] s;
    s = 5'(i);
    return v[s];
  endfunction

  function automatic logic [DATA_W-1:0] byteAt(input logic [NREQ*DATA_W-1:0] v, input int i);
    logic [NREQ*DATA_W-1:0] t;
    t = v >> (i * DATA_W);
    return t[DATA_W-1:0];
  endfunction

  function automatic logic [NREQ*DATA_W-1:0] randData();
    return (NREQ*DATA_W)'($urandom);
  endfunction

  function automatic logic [NREQ-1:0] randValid();
    logic [NREQ-1:0] v;
    v = '0;
    for (int i = 0; i < NREQ; i++) begin
      if ($urandom_range(0, 2) == 0) v = v | (NREQ'(1) << i);
    end
    return v;
  endfunction

  // First pending index in the order last+1, last+2, ... wrapping, ending at last
  function automatic int rrPick();
    for (int k = 1; k <= NREQ; k++) begin
      int cand;
      cand = (mLast + k) % NREQ;
      if (bitAt(32'(mPending), cand)) return cand;
    end
    return -1;
  endfunction

  // Advance the reference model across the coming rising edge using the inputs just driven
  task automatic modelEdge();
    logic [NREQ-1:0]        newPending;
    logic [NREQ*DATA_W-1:0] mask;
    int                     w;
    if (rst_n === 1'b0) begin
      mPending   = '0;
      mLast      = NREQ - 1;
      mInFrame   = 1'b0;
      mBusySeen  = 1'b0;
      modelKnown = 1'b1;
      return;
    end
    if (!modelKnown) return;
    newPending = mPending;
    if (mInFrame) begin
      if (tx_busy === 1'b1) begin
        mBusySeen = 1'b1;
      end else if (mBusySeen) begin
        newPending = newPending & ~(NREQ'(1) << mGrant);
        mLast      = mGrant;
        mInFrame   = 1'b0;
        mBusySeen  = 1'b0;
      end
    end else if (mPending != '0) begin
      w        = rrPick();
      mGrant   = w;
      mCurByte = byteAt(mHoldV, w);
      expQ.push_back('{cyc + 1, w, mCurByte});
      mInFrame  = 1'b1;
      mBusySeen = 1'b0;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bitAt(32'(req_valid), i) && !bitAt(32'(mPending), i)) begin
        newPending = newPending | (NREQ'(1) << i);
        mask       = (NREQ*DATA_W)'({DATA_W{1'b1}}) << (i * DATA_W);
        mHoldV     = (mHoldV & ~mask) | (req_data & mask);
      end
    end
    mPending = newPending;
  endtask

  // Per-cycle comparison of handshake and status outputs against the model
  task automatic checkOutput();
    logic [NREQ-1:0] expReady;
    if (!modelKnown) return;
    expReady = ~mPending;
    compare("req_ready", 32'(req_ready), 32'(expReady));
    compare("busy", 32'(busy), 32'(mInFrame));
    if (mInFrame) compare("tx_data_stable", 32'(tx_data), 32'(mCurByte));
  endtask

  // Drive one cycle of inputs at the falling edge, check current outputs, then step the model
  task automatic applyStimulus(input logic r, input logic [NREQ-1:0] v, input logic [NREQ*DATA_W-1:0] d);
    @(negedge clk);
    rst_n     = r;
    req_valid = v;
    req_data  = d;
    checkOutput();
    modelEdge();
  endtask

  task automatic runIdle(input int budget);
    int n;
    n = 0;
    while ((mInFrame || mPending != '0 || expQ.size() != 0) && n < budget) begin
      applyStimulus(1'b1, '0, randData());
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: still busy after %0d cycles, expected idle", budget);
    end
  endtask

  task automatic resetOne();
    applyStimulus(1'b0, '0, '0);
  endtask

  // Transmitter model: answers tx_start with busy after a short delay, aborts on reset
  initial begin
    tx_busy  = 1'b0;
    txActive = 1'b0;
    txDelay  = 0;
    txHold   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n === 1'b0) begin
        tx_busy  = 1'b0;
        txActive = 1'b0;
      end else begin
        if (!txActive && tx_start === 1'b1) begin
          txActive = 1'b1;
          txDelay  = txFixed ? 1 : int'($urandom_range(0, 3));
          txHold   = txFixed ? 10 : int'($urandom_range(3, 10));
        end
        if (txActive) begin
          if (txDelay > 0) begin
            txDelay--;
          end else if (txHold > 0) begin
            tx_busy = 1'b1;
            txHold--;
          end else begin
            tx_busy  = 1'b0;
            txActive = 1'b0;
          end
        end
      end
    end
  end

  // Scoreboard monitor: every tx_start must match the oldest predicted launch
  always @(negedge clk) begin
    if (modelKnown) begin
      if (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("[TB] FAIL missing_tx_start: no launch observed, expected in cycle %0d (grant %0d)", expQ[0].cyc, expQ[0].grant);
        void'(expQ.pop_front());
      end
      if (tx_start === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_tx_start: tx_start=1 grant %0d data 0x%0h, expected no launch (cycle %0d)", grant_id, tx_data, cyc);
        end else begin
          monExp = expQ.pop_front();
          compare("start_cycle", 32'(cyc), 32'(monExp.cyc));
          compare("grant_id", 32'(grant_id), 32'(monExp.grant));
          compare("tx_data", 32'(tx_data), 32'(monExp.data));
          if (logGrants) grantLog.push_back(int'(grant_id));
        end
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    txFixed   = 1'b1;
    logGrants = 1'b0;
    mHoldV    = '0;

    // Reset held three cycles with every requester asserting valid
    repeat (3) applyStimulus(1'b0, {NREQ{1'b1}}, {(NREQ*DATA_W){1'b1}});
    applyStimulus(1'b1, '0, '0);
    compare("reset_tx_start", 32'(tx_start), 32'h0);
    compare("reset_busy", 32'(busy), 32'h0);
    compare("reset_tx_data", 32'(tx_data), 32'h0);
    compare("reset_grant_id", 32'(grant_id), 32'h0);
    compare("reset_req_ready", 32'(req_ready), 32'h7);

    // Single request from requester 0, busy held for ten cycles
    applyStimulus(1'b1, 3'b001, 24'h0000A5);
    runIdle(60);

    // Two simultaneous requests straight out of reset
    resetOne();
    grantLog.delete();
    logGrants = 1'b1;
    applyStimulus(1'b1, 3'b011, 24'h002211);
    runIdle(80);
    logGrants = 1'b0;
    compare("simul_frames", 32'(grantLog.size()), 32'd2);
    if (grantLog.size() >= 2) begin
      compare("simul_first", 32'(grantLog[0]), 32'd0);
      compare("simul_second", 32'(grantLog[1]), 32'd1);
    end

    // Fairness with all requesters reloading as soon as they are ready
    txFixed = 1'b0;
    resetOne();
    grantLog.delete();
    logGrants = 1'b1;
    for (int n = 0; n < 400 && grantLog.size() < 9; n++) begin
      applyStimulus(1'b1, {NREQ{1'b1}}, randData());
    end
    runIdle(120);
    logGrants = 1'b0;
    if (grantLog.size() < 9) begin
      checks++;
      errors++;
      $display("[TB] FAIL fair_count: got %0d grants, expected at least 9", grantLog.size());
    end else begin
      for (int k = 0; k < 9; k++) compare("fair_grant", 32'(grantLog[k]), 32'(k % NREQ));
    end

    // Blocked overwrite: 0xFF offered continuously while 0x3C is still in flight
    txFixed = 1'b1;
    resetOne();
    applyStimulus(1'b1, 3'b010, 24'h003C00);
    repeat (25) applyStimulus(1'b1, 3'b010, 24'h00FF00);
    runIdle(60);

    // Reset in the middle of a frame with requester 1 still pending
    resetOne();
    applyStimulus(1'b1, 3'b011, 24'h007766);
    for (int n = 0; n < 30 && !(mInFrame && mBusySeen); n++) applyStimulus(1'b1, '0, '0);
    if (!(mInFrame && mBusySeen)) begin
      checks++;
      errors++;
      $display("[TB] FAIL midreset_setup: frame not in progress, expected transmitter busy");
    end
    repeat (2) applyStimulus(1'b1, '0, '0);
    resetOne();
    repeat (20) applyStimulus(1'b1, '0, '0);
    compare("midreset_ready", 32'(req_ready), 32'h7);

    // Randomized traffic with random transmitter timing
    txFixed = 1'b0;
    resetOne();
    for (int n = 0; n < 1500; n++) applyStimulus(1'b1, randValid(), randData());
    runIdle(300);

    compare("scoreboard_empty", 32'(expQ.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
